// File: rtl/reg_scan_disp.sv
// reg_scan_disp: walks the CPU debug register port and shows the selected
// 32-bit register as 8 hex digits on a time-multiplexed, active-low
// seven-segment display. It can hold a switch-selected register or
// auto-step through registers 0..31.
module reg_scan_disp #(
    parameter int CLK_DIV = 50000,
    parameter int HOLD    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        auto,
    input  logic [4:0]  sel_sw,
    input  logic [31:0] reg_data,
    output logic [4:0]  reg_sel,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int FRM_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [FRM_W-1:0] HOLD_LAST = FRM_W'(HOLD - 1);

    // Hex nibble to active-low segment pattern {dp,g,f,e,d,c,b,a}, dp off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'h0:    pat = 8'hC0;
            4'h1:    pat = 8'hF9;
            4'h2:    pat = 8'hA4;
            4'h3:    pat = 8'hB0;
            4'h4:    pat = 8'h99;
            4'h5:    pat = 8'h92;
            4'h6:    pat = 8'h82;
            4'h7:    pat = 8'hF8;
            4'h8:    pat = 8'h80;
            4'h9:    pat = 8'h90;
            4'hA:    pat = 8'h88;
            4'hB:    pat = 8'h83;
            4'hC:    pat = 8'hC6;
            4'hD:    pat = 8'hA1;
            4'hE:    pat = 8'h86;
            4'hF:    pat = 8'h8E;
            default: pat = 8'hFF;
        endcase
        return pat;
    endfunction

    logic [DIV_W-1:0] div_cnt_q,   div_cnt_d;
    logic [2:0]       digit_q,     digit_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [4:0]       reg_sel_q,   reg_sel_d;
    logic [31:0]      shadow_q,    shadow_d;

    logic tick_s;
    logic frame_end_s;
    logic frame_start_s;

    // Next-state logic: slot divider, digit scan, register selection, snapshot.
    always_comb begin
        tick_s        = (div_cnt_q == DIV_LAST);
        frame_end_s   = tick_s && (digit_q == 3'd7);
        frame_start_s = (digit_q == 3'd0) && (div_cnt_q == '0);

        if (tick_s) begin
            div_cnt_d = '0;
            digit_d   = digit_q + 3'd1;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
            digit_d   = digit_q;
        end

        frame_cnt_d = frame_cnt_q;
        reg_sel_d   = reg_sel_q;
        if (auto) begin
            // Scanning resumes from the current reg_sel; frame_cnt is already
            // 0 when coming out of manual mode.
            if (frame_end_s) begin
                if (frame_cnt_q == HOLD_LAST) begin
                    frame_cnt_d = '0;
                    reg_sel_d   = reg_sel_q + 5'd1;
                end else begin
                    frame_cnt_d = frame_cnt_q + FRM_W'(1);
                end
            end else begin
                frame_cnt_d = frame_cnt_q;
            end
        end else begin
            frame_cnt_d = '0;
            reg_sel_d   = sel_sw;
        end

        // reg_sel last changed at the previous frame_end, so reg_data has
        // settled to the current register by the first cycle of the frame.
        if (frame_start_s) begin
            shadow_d = reg_data;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // State registers with synchronous reset that discards all progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q   <= '0;
            digit_q     <= 3'd0;
            frame_cnt_q <= '0;
            reg_sel_q   <= 5'd0;
            shadow_q    <= 32'd0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            digit_q     <= digit_d;
            frame_cnt_q <= frame_cnt_d;
            reg_sel_q   <= reg_sel_d;
            shadow_q    <= shadow_d;
        end
    end

    // Display decode from registered state only; digit 0 is the rightmost
    // digit and carries the least significant nibble.
    always_comb begin
        an  = ~(8'h01 << digit_q);
        seg = hex_to_seg(shadow_q[{digit_q, 2'b00} +: 4]);
    end

    assign reg_sel = reg_sel_q;

endmodule

// File: tb/tb_reg_scan_disp.sv
// Scoreboard bench for reg_scan_disp with CLK_DIV=4, HOLD=2.
// Stimulus pushes expected display/select values tagged with the cycle they
// apply to; an independent monitor pops and compares on the falling edge.
module tb_reg_scan_disp;

    logic        clk;
    logic        rst;
    logic        auto_i;
    logic [4:0]  sel_sw;
    logic [31:0] data_drv;
    logic        use_model;
    logic [31:0] reg_data;
    logic [4:0]  sel_w;
    logic [7:0]  an_w;
    logic [7:0]  seg_w;

    reg_scan_disp #(.CLK_DIV(4), .HOLD(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .auto     (auto_i),
        .sel_sw   (sel_sw),
        .reg_data (reg_data),
        .reg_sel  (sel_w),
        .an       (an_w),
        .seg      (seg_w)
    );

    // CPU register file stand-in: register r holds r * 0x11.
    assign reg_data = use_model ? ({27'd0, sel_w} * 32'h11) : data_drv;

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] an;
        logic [7:0] seg;
        logic [4:0] sel;
        bit         c_an;
        bit         c_seg;
        bit         c_sel;
    } exp_t;

    exp_t sbq[$];
    int   cyc_cnt;
    int   checks;
    int   errors;

    logic [7:0] pat    [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [7:0] an_tab [8]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] seg2_tab [8] = '{8'h8E, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc_cnt = 0;
        forever begin
            @(posedge clk);
            cyc_cnt = cyc_cnt + 1;
        end
    end

    // Monitor: compare every entry due in this cycle, away from the active edge.
    initial begin
        exp_t e;
        checks = 0;
        errors = 0;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].cyc <= cyc_cnt) begin
                e = sbq.pop_front();
                if (e.cyc < cyc_cnt) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL %s stale entry cyc %0d seen at %0d", e.name, e.cyc, cyc_cnt);
                end else begin
                    if (e.c_an) begin
                        checks = checks + 1;
                        if (an_w !== e.an) begin
                            errors = errors + 1;
                            $display("FAIL %s an got %h want %h (cyc %0d)", e.name, an_w, e.an, cyc_cnt);
                        end
                    end
                    if (e.c_seg) begin
                        checks = checks + 1;
                        if (seg_w !== e.seg) begin
                            errors = errors + 1;
                            $display("FAIL %s seg got %h want %h (cyc %0d)", e.name, seg_w, e.seg, cyc_cnt);
                        end
                    end
                    if (e.c_sel) begin
                        checks = checks + 1;
                        if (sel_w !== e.sel) begin
                            errors = errors + 1;
                            $display("FAIL %s reg_sel got %0d want %0d (cyc %0d)", e.name, sel_w, e.sel, cyc_cnt);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string nm, input logic [7:0] a, input logic [7:0] s,
                              input logic [4:0] r, input bit ca, input bit cs, input bit cr);
        exp_t e;
        e.cyc   = cyc_cnt;
        e.name  = nm;
        e.an    = a;
        e.seg   = s;
        e.sel   = r;
        e.c_an  = ca;
        e.c_seg = cs;
        e.c_sel = cr;
        sbq.push_back(e);
    endtask

    task automatic do_reset(input int n, input logic [31:0] d);
        rst      = 1'b1;
        data_drv = d;
        for (int i = 0; i < n; i++) begin
            step();
            expect_now("rst_state", 8'hFE, 8'hC0, 5'd0, 1'b1, 1'b1, 1'b1);
        end
        rst = 1'b0;
    endtask

    function automatic logic [7:0] seg_of(input logic [31:0] v, input int d);
        logic [3:0] nib;
        nib = v[4*d +: 4];
        return pat[nib];
    endfunction

    initial begin
        int          d;
        int          r;
        logic [31:0] sh;
        logic [4:0]  rs;

        rst       = 1'b1;
        auto_i    = 1'b0;
        sel_sw    = 5'd0;
        data_drv  = 32'h1234ABCD;
        use_model = 1'b0;

        // Reset held 3 cycles, then first snapshot on the first edge after release.
        do_reset(3, 32'h1234ABCD);
        step();
        expect_now("first_snap", 8'hFE, 8'hA1, 5'd0, 1'b1, 1'b1, 1'b1);
        step();
        expect_now("first_snap2", 8'hFE, 8'hA1, 5'd0, 1'b1, 1'b1, 1'b1);

        // Digit scan of 0123456F, each slot held 4 cycles, then repeating.
        do_reset(1, 32'h0123456F);
        for (int k = 1; k <= 40; k++) begin
            step();
            d = (k / 4) % 8;
            expect_now("digit_scan", an_tab[d], seg2_tab[d], 5'd0, 1'b1, 1'b1, 1'b1);
        end

        // Auto scan through all 32 registers and back to 0.
        use_model = 1'b1;
        auto_i    = 1'b1;
        do_reset(1, 32'h0);
        for (int k = 1; k <= 2112; k++) begin
            step();
            d  = (k / 4) % 8;
            r  = ((k - 1) / 64) % 32;
            sh = r * 17;
            rs = 5'((k / 64) % 32);
            expect_now("auto_scan", an_tab[d], seg_of(sh, d), rs, 1'b1, 1'b1, 1'b1);
        end

        // Manual mode: select follows the switch a cycle later, display at frame start.
        auto_i = 1'b0;
        sel_sw = 5'd0;
        do_reset(1, 32'h0);
        for (int k = 1; k <= 72; k++) begin
            step();
            d = (k / 4) % 8;
            if (k <= 10)      rs = 5'd0;
            else if (k <= 40) rs = 5'd17;
            else              rs = 5'd5;
            if (k <= 32)      sh = 32'h0;
            else if (k <= 64) sh = 32'h121;
            else              sh = 32'h55;
            expect_now("manual", an_tab[d], seg_of(sh, d), rs, 1'b1, 1'b1, 1'b1);
            if (k == 10) sel_sw = 5'd17;
            if (k == 40) sel_sw = 5'd5;
        end

        // Manual -> auto from reg_sel 30, then reset mid-hold at digit 5.
        auto_i = 1'b0;
        sel_sw = 5'd30;
        do_reset(1, 32'h0);
        step();
        expect_now("mode_sel30", 8'hFE, 8'h00, 5'd30, 1'b1, 1'b0, 1'b1);
        auto_i = 1'b1;
        for (int k = 2; k <= 180; k++) begin
            step();
            if (k == 63)  expect_now("mode_hold30", 8'h00, 8'h00, 5'd30, 1'b0, 1'b0, 1'b1);
            if (k == 64)  expect_now("mode_to31",   8'h00, 8'h00, 5'd31, 1'b0, 1'b0, 1'b1);
            if (k == 127) expect_now("mode_hold31", 8'h00, 8'h00, 5'd31, 1'b0, 1'b0, 1'b1);
            if (k == 128) expect_now("mode_wrap0",  8'h00, 8'h00, 5'd0,  1'b0, 1'b0, 1'b1);
            if (k == 180) expect_now("mode_dig5",   8'hDF, 8'h00, 5'd0,  1'b1, 1'b0, 1'b1);
        end
        rst    = 1'b1;
        auto_i = 1'b0;
        step();
        expect_now("midhold_rst", 8'hFE, 8'hC0, 5'd0, 1'b1, 1'b1, 1'b1);
        rst    = 1'b0;
        auto_i = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            step();
            if (k == 1)  expect_now("post_rst_k1",  8'hFE, 8'hC0, 5'd0, 1'b1, 1'b1, 1'b1);
            if (k == 32) expect_now("post_rst_k32", 8'hFE, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1);
            if (k == 63) expect_now("post_rst_k63", 8'h00, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1);
            if (k == 64) expect_now("post_rst_k64", 8'hFE, 8'h00, 5'd1, 1'b1, 1'b0, 1'b1);
        end

        step();
        step();
        if (sbq.size() != 0) begin
            $display("FAIL drain %0d entries left in scoreboard", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors + sbq.size());
        $finish;
    end

endmodule
